bti_arb2: RTL and testbench
===========================

Name: bti_arb2

Overview:
- Two-to-one BTI bus arbiter that merges the core's instruction port and data port onto a single shared BTI master port.
- Sits between the core's bus interface unit and a unified memory or interconnect.
- Arbitrates requests round-robin and tracks the source of every outstanding transaction in order.
- Routes each in-order response back to the requester that issued it.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, write/read data width; strobe width is DATA_W/8.
- MAX_OS, 4, maximum outstanding transactions on the shared port; power of two, minimum 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_bti_req_slv  bti_req_if_t.slv  -  instruction-side request (vld, rdy, addr, wr, wdata, wstrb)
- i_bti_rsp_mst  bti_rsp_if_t.mst  -  instruction-side response (vld, rdy, rdata, err)
- d_bti_req_slv  bti_req_if_t.slv  -  data-side request
- d_bti_rsp_mst  bti_rsp_if_t.mst  -  data-side response
- bti_req_mst  bti_req_if_t.mst  -  shared downstream request
- bti_rsp_slv  bti_rsp_if_t.slv  -  shared downstream response
- proto_err  out  1  sticky flag: a response arrived with no outstanding transaction

Behaviour:
- **Reset values:**
  - Tracking FIFO empty (count=0).
  - Priority pointer = D (data wins the first tie).
  - No grant lock; proto_err=0.
  - All vld outputs are 0 while in reset, because the FIFO is empty and no response can be forwarded.
- **Request path:** zero-cycle combinational pass-through of the granted requester's vld/addr/wr/wdata/wstrb to bti_req_mst.
  - Ungranted requester sees rdy=0.
- **Accept condition:** req accepted when bti_req_mst.vld && bti_req_mst.rdy && !full.
  - When full, bti_req_mst.vld is forced to 0 and both requester rdy are 0.
- **Grant:**
  - Only one requester valid: grant it.
  - Both valid: grant the one the pointer favours.
  - After each accepted request, the pointer moves to favour the non-granted side.
- **Lock:** if the granted request is presented downstream but not accepted (rdy=0), the grant is held in a registered lock bit until acceptance. No switching mid-handshake; BTI vld/payload must stay stable.
- **Tracking FIFO:**
  - MAX_OS entries of 1-bit source ID (0=I, 1=D).
  - Push on accept; pop on response handshake.
  - Pointers wrap modulo MAX_OS; count is $clog2(MAX_OS)+1 bits.
- **Full with simultaneous pop:** full is evaluated from the registered count only. A pop does not free a slot in the same cycle, so there is no rsp-to-req combinational path.
- **Simultaneous push and pop when not full:** count unchanged, both pointers advance.
- **Response path:** zero-cycle combinational.
  - FIFO head selects the destination; rdata/err/vld are forwarded to that port only; the other port's vld=0.
  - bti_rsp_slv.rdy = selected port rdy.
  - Back-pressure from a stalled requester blocks all responses, as required for in-order delivery.
- **Response with FIFO empty:** protocol error.
  - bti_rsp_slv.rdy=1 so the beat is dropped.
  - No forwarding; proto_err set and held until reset.
- **Reset mid-operation:** all tracking state is discarded; any in-flight downstream transaction is lost. Downstream must be reset together with this block.

Decomposition:
- bti_pkg holds:
  - bti_src_e (SRC_I, SRC_D)
  - BTI_ADDR_W / BTI_DATA_W defaults
  - the request/response payload structs shared by the bti_req_if_t/bti_rsp_if_t interfaces
- One sub-module: bti_src_fifo, a parameterised synchronous FIFO (width, depth) with full/empty/count, async active-low reset. It is reusable by later multi-master arbiters.

Test Plan:
- **I-only fetch stream:** I issues 3 reads (addr 0x0,0x4,0x8), downstream rdy=1, responses return 2 cycles later → I receives rdata in order, D sees no vld, proto_err=0.
- **Contention:** I and D both valid every cycle for 6 accepts → grants alternate D,I,D,I,D,I; responses routed to matching ports.
- **Lock:** D valid, downstream rdy=0 for 3 cycles while I becomes valid → grant stays on D; addr/wdata stable; D accepted on cycle 4, then I.
- **Outstanding limit:** MAX_OS=4, 4 accepts with no response → 5th request sees rdy=0. Response with rsp+req in the same cycle → req still blocked that cycle and accepted the next.
- **Response back-pressure:** head=I with I rsp rdy=0 for 2 cycles, D response next → bti_rsp_slv.rdy=0 for 2 cycles; D response is delivered only after the I response completes.
- **Spurious response:** bti_rsp_slv.vld=1 with FIFO empty → beat consumed, no requester vld, proto_err=1 and held until rst_n low, which clears it.

Source files
------------

// File: rtl/bti_pkg.sv
// Shared BTI definitions: source IDs, default widths and the request/response
// payload structs carried by the bti_req_if_t / bti_rsp_if_t interfaces.
package bti_pkg;

  localparam int unsigned BTI_ADDR_W = 32;
  localparam int unsigned BTI_DATA_W = 32;

  // Source ID stored per outstanding transaction
  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } bti_src_e;

  typedef struct packed {
    logic [BTI_ADDR_W-1:0]   addr;
    logic                    wr;
    logic [BTI_DATA_W-1:0]   wdata;
    logic [BTI_DATA_W/8-1:0] wstrb;
  } bti_req_pld_t;

  typedef struct packed {
    logic [BTI_DATA_W-1:0] rdata;
    logic                  err;
  } bti_rsp_pld_t;

endpackage

// File: rtl/bti_req_if_t.sv
// BTI request channel: vld/rdy handshake plus the bti_req_pld_t fields.
// mst drives the request, slv accepts it.
interface bti_req_if_t #(
  parameter int unsigned ADDR_W = bti_pkg::BTI_ADDR_W,
  parameter int unsigned DATA_W = bti_pkg::BTI_DATA_W
);
  logic                vld;
  logic                rdy;
  logic [ADDR_W-1:0]   addr;
  logic                wr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  modport mst (output vld, addr, wr, wdata, wstrb, input rdy);
  modport slv (input vld, addr, wr, wdata, wstrb, output rdy);
endinterface

// File: rtl/bti_rsp_if_t.sv
// BTI response channel: vld/rdy handshake plus the bti_rsp_pld_t fields.
// mst drives the response, slv accepts it.
interface bti_rsp_if_t #(
  parameter int unsigned DATA_W = bti_pkg::BTI_DATA_W
);
  logic              vld;
  logic              rdy;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport mst (output vld, rdata, err, input rdy);
  modport slv (input vld, rdata, err, output rdy);
endinterface

// File: rtl/bti_src_fifo.sv
// Parameterised synchronous FIFO with full/empty/count flags.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, wdata    : write side (ignored when full)
//   pop, rdata     : read side; rdata is the current head (ignored when empty)
//   full, empty    : derived from the registered count only
//   count          : number of stored entries
module bti_src_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bti_arb2.sv
// Two-to-one BTI arbiter merging the instruction and data ports onto one
// shared master port. Round-robin grant with a lock while a request is held
// downstream; an in-order FIFO of source IDs routes responses back.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_bti_req_slv  : instruction request in      i_bti_rsp_mst : instruction response out
//   d_bti_req_slv  : data request in             d_bti_rsp_mst : data response out
//   bti_req_mst    : shared request out          bti_rsp_slv   : shared response in
//   proto_err      : sticky, response seen with nothing outstanding
module bti_arb2
  import bti_pkg::*;
#(
  parameter int unsigned ADDR_W = BTI_ADDR_W,
  parameter int unsigned DATA_W = BTI_DATA_W,
  parameter int unsigned MAX_OS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  bti_req_if_t.slv    i_bti_req_slv,
  bti_rsp_if_t.mst    i_bti_rsp_mst,
  bti_req_if_t.slv    d_bti_req_slv,
  bti_rsp_if_t.mst    d_bti_rsp_mst,
  bti_req_if_t.mst    bti_req_mst,
  bti_rsp_if_t.slv    bti_rsp_slv,
  output logic        proto_err
);

  localparam int unsigned CntW = $clog2(MAX_OS) + 1;

  bti_src_e            ptr_q, lock_src_q, gnt, head_src;
  logic                lock_q, proto_err_q;
  logic                fifo_full, fifo_empty, fifo_head;
  logic [CntW-1:0]     fifo_cnt;
  logic                sel_vld, sel_wr, req_vld, accept, rsp_vld, rsp_pop;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;

  // Grant: the lock overrides everything so a stalled request stays stable
  always_comb begin
    gnt = SRC_I;
    if (lock_q) begin
      gnt = lock_src_q;
    end else if (i_bti_req_slv.vld && d_bti_req_slv.vld) begin
      gnt = ptr_q;
    end else if (d_bti_req_slv.vld) begin
      gnt = SRC_D;
    end
  end

  always_comb begin
    if (gnt == SRC_D) begin
      sel_vld   = d_bti_req_slv.vld;
      sel_addr  = d_bti_req_slv.addr;
      sel_wr    = d_bti_req_slv.wr;
      sel_wdata = d_bti_req_slv.wdata;
      sel_wstrb = d_bti_req_slv.wstrb;
    end else begin
      sel_vld   = i_bti_req_slv.vld;
      sel_addr  = i_bti_req_slv.addr;
      sel_wr    = i_bti_req_slv.wr;
      sel_wdata = i_bti_req_slv.wdata;
      sel_wstrb = i_bti_req_slv.wstrb;
    end
  end

  // Full comes from the registered count, so a same-cycle pop never frees a
  // slot and there is no response-to-request combinational path.
  assign req_vld           = sel_vld && !fifo_full;
  assign accept            = req_vld && bti_req_mst.rdy;
  assign bti_req_mst.vld   = req_vld;
  assign bti_req_mst.addr  = sel_addr;
  assign bti_req_mst.wr    = sel_wr;
  assign bti_req_mst.wdata = sel_wdata;
  assign bti_req_mst.wstrb = sel_wstrb;
  assign i_bti_req_slv.rdy = (gnt == SRC_I) && !fifo_full && bti_req_mst.rdy;
  assign d_bti_req_slv.rdy = (gnt == SRC_D) && !fifo_full && bti_req_mst.rdy;

  // Response routing by FIFO head; with nothing outstanding the beat is sunk
  assign head_src            = bti_src_e'(fifo_head);
  assign rsp_vld             = bti_rsp_slv.vld && !fifo_empty;
  assign i_bti_rsp_mst.vld   = rsp_vld && (head_src == SRC_I);
  assign d_bti_rsp_mst.vld   = rsp_vld && (head_src == SRC_D);
  assign i_bti_rsp_mst.rdata = bti_rsp_slv.rdata;
  assign i_bti_rsp_mst.err   = bti_rsp_slv.err;
  assign d_bti_rsp_mst.rdata = bti_rsp_slv.rdata;
  assign d_bti_rsp_mst.err   = bti_rsp_slv.err;
  assign bti_rsp_slv.rdy     = fifo_empty ? 1'b1 :
                               (head_src == SRC_D) ? d_bti_rsp_mst.rdy : i_bti_rsp_mst.rdy;
  assign rsp_pop             = rsp_vld && bti_rsp_slv.rdy;
  assign proto_err           = proto_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= SRC_D;
      lock_q      <= 1'b0;
      lock_src_q  <= SRC_I;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) begin
        ptr_q  <= (gnt == SRC_D) ? SRC_I : SRC_D;
        lock_q <= 1'b0;
      end else begin
        // Releases by itself if the locked requester ever drops vld
        lock_q     <= req_vld;
        lock_src_q <= gnt;
      end
      if (bti_rsp_slv.vld && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  bti_src_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OS)
  ) u_src_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (gnt),
    .pop   (rsp_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_cnt <= CntW'(MAX_OS));

endmodule

// File: tb/tb_bti_arb2.sv
module tb_bti_arb2;
  import bti_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic proto_err;
  always #5 clk = ~clk;

  bti_req_if_t i_req ();
  bti_req_if_t d_req ();
  bti_req_if_t ds_req ();
  bti_rsp_if_t i_rsp ();
  bti_rsp_if_t d_rsp ();
  bti_rsp_if_t ds_rsp ();

  bti_arb2 #(
    .ADDR_W (32),
    .DATA_W (32),
    .MAX_OS (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_bti_req_slv (i_req),
    .i_bti_rsp_mst (i_rsp),
    .d_bti_req_slv (d_req),
    .d_bti_rsp_mst (d_rsp),
    .bti_req_mst   (ds_req),
    .bti_rsp_slv   (ds_rsp),
    .proto_err     (proto_err)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int           n_vec = 0;
  int           n_bad = 0;
  int           cyc = 0;
  bti_req_pld_t iq[$], dq[$], exp_gnt[$];
  bti_rsp_pld_t exp_i[$], exp_d[$];
  pend_t        pend[$];
  logic         i_hs = 1'b0, d_hs = 1'b0, rsp_hs = 1'b0;
  logic         rsp_en = 1'b1, spur = 1'b0, cur_spur = 1'b0;
  bti_rsp_pld_t rr;

  // Downstream memory model: response payload as a fixed function of address
  function automatic bti_rsp_pld_t mem_rsp(input logic [31:0] a);
    bti_rsp_pld_t r;
    r.rdata = a ^ 32'hA5A5_5A5A;
    r.err   = a[4];
    return r;
  endfunction

  function automatic bti_req_pld_t mk(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    bti_req_pld_t p;
    p.addr  = a;
    p.wr    = wr;
    p.wdata = wr ? wd : 32'h0;
    p.wstrb = wr ? 4'hF : 4'h0;
    return p;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input bti_src_e src, input logic [31:0] a, input logic wr,
                       input logic [31:0] wd);
    if (src == SRC_I) begin
      iq.push_back(mk(a, wr, wd));
      exp_i.push_back(mem_rsp(a));
    end else begin
      dq.push_back(mk(a, wr, wd));
      exp_d.push_back(mem_rsp(a));
    end
  endtask

  task automatic exp_acc(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    exp_gnt.push_back(mk(a, wr, wd));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((iq.size() + dq.size() + exp_gnt.size() + exp_i.size() + exp_d.size()
            + pend.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drain"}, 96'(n < 200), 96'(1));
    step();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard: downstream accept order and routed responses
  always @(negedge clk) begin
    bti_req_pld_t got, e;
    bti_rsp_pld_t r, er;
    i_hs   = rst_n && i_req.vld && i_req.rdy;
    d_hs   = rst_n && d_req.vld && d_req.rdy;
    rsp_hs = rst_n && ds_rsp.vld && ds_rsp.rdy;
    if (rst_n) begin
      if (ds_req.vld && ds_req.rdy) begin
        chk("accept_expected", 96'(exp_gnt.size() != 0), 96'(1));
        got = '{addr: ds_req.addr, wr: ds_req.wr, wdata: ds_req.wdata, wstrb: ds_req.wstrb};
        if (exp_gnt.size() != 0) begin
          e = exp_gnt.pop_front();
          chk("grant_order", 96'(got), 96'(e));
        end
        pend.push_back('{addr: ds_req.addr, due: cyc + 2});
      end
      if (i_rsp.vld && i_rsp.rdy) begin
        chk("i_rsp_expected", 96'(exp_i.size() != 0), 96'(1));
        if (exp_i.size() != 0) begin
          er = exp_i.pop_front();
          r  = '{rdata: i_rsp.rdata, err: i_rsp.err};
          chk("i_rsp_data", 96'(r), 96'(er));
        end
      end
      if (d_rsp.vld && d_rsp.rdy) begin
        chk("d_rsp_expected", 96'(exp_d.size() != 0), 96'(1));
        if (exp_d.size() != 0) begin
          er = exp_d.pop_front();
          r  = '{rdata: d_rsp.rdata, err: d_rsp.err};
          chk("d_rsp_data", 96'(r), 96'(er));
        end
      end
    end
  end

  // Instruction requester
  initial begin
    i_req.vld = 1'b0; i_req.addr = '0; i_req.wr = 1'b0; i_req.wdata = '0; i_req.wstrb = '0;
    forever begin
      @(posedge clk);
      #2;
      if (i_hs && iq.size() != 0) iq.delete(0);
      if (iq.size() != 0) begin
        i_req.vld = 1'b1; i_req.addr = iq[0].addr; i_req.wr = iq[0].wr;
        i_req.wdata = iq[0].wdata; i_req.wstrb = iq[0].wstrb;
      end else begin
        i_req.vld = 1'b0;
      end
    end
  end

  // Data requester
  initial begin
    d_req.vld = 1'b0; d_req.addr = '0; d_req.wr = 1'b0; d_req.wdata = '0; d_req.wstrb = '0;
    forever begin
      @(posedge clk);
      #2;
      if (d_hs && dq.size() != 0) dq.delete(0);
      if (dq.size() != 0) begin
        d_req.vld = 1'b1; d_req.addr = dq[0].addr; d_req.wr = dq[0].wr;
        d_req.wdata = dq[0].wdata; d_req.wstrb = dq[0].wstrb;
      end else begin
        d_req.vld = 1'b0;
      end
    end
  end

  // Downstream responder, in order, at least two cycles after accept
  initial begin
    ds_rsp.vld = 1'b0; ds_rsp.rdata = '0; ds_rsp.err = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (rsp_hs && !cur_spur && pend.size() != 0) pend.delete(0);
      cur_spur = 1'b0;
      if (spur) begin
        ds_rsp.vld = 1'b1; ds_rsp.rdata = 32'hBAD0_BAD0; ds_rsp.err = 1'b1;
        cur_spur = 1'b1;
      end else if (rsp_en && pend.size() != 0 && pend[0].due <= cyc) begin
        rr = mem_rsp(pend[0].addr);
        ds_rsp.vld = 1'b1; ds_rsp.rdata = rr.rdata; ds_rsp.err = rr.err;
      end else begin
        ds_rsp.vld = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    ds_req.rdy = 1'b1;
    i_rsp.rdy  = 1'b1;
    d_rsp.rdy  = 1'b1;

    // Reset: a response beat during reset must not be forwarded
    spur = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_vld", 96'(ds_req.vld), 96'(0));
    chk("rst_i_rsp_vld", 96'(i_rsp.vld), 96'(0));
    chk("rst_d_rsp_vld", 96'(d_rsp.vld), 96'(0));
    chk("rst_rsp_rdy", 96'(ds_rsp.rdy), 96'(1));
    chk("rst_proto_err", 96'(proto_err), 96'(0));
    spur = 1'b0;
    @(posedge clk);
    step();
    rst_n = 1'b1;
    step();

    // I-only fetch stream
    for (int k = 0; k < 3; k++) begin
      issue(SRC_I, 32'(4 * k), 1'b0, 32'h0);
      exp_acc(32'(4 * k), 1'b0, 32'h0);
    end
    drain("ionly");
    chk("ionly_proto_err", 96'(proto_err), 96'(0));

    // Contention straight after reset: D first, then alternate
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      issue(SRC_I, 32'h100 + 32'(4 * k), 1'b0, 32'h0);
      issue(SRC_D, 32'h200 + 32'(4 * k), 1'b1, 32'hD000_0000 + 32'(k));
    end
    for (int k = 0; k < 3; k++) begin
      exp_acc(32'h200 + 32'(4 * k), 1'b1, 32'hD000_0000 + 32'(k));
      exp_acc(32'h100 + 32'(4 * k), 1'b0, 32'h0);
    end
    drain("contend");

    // Make the pointer favour I, so only the lock can keep D granted
    issue(SRC_D, 32'h2F0, 1'b0, 32'h0);
    exp_acc(32'h2F0, 1'b0, 32'h0);
    drain("pre_lock");

    // Lock: D stalled downstream for 3 cycles while I becomes valid
    ds_req.rdy = 1'b0;
    issue(SRC_D, 32'h300, 1'b1, 32'hCAFE_0300);
    exp_acc(32'h300, 1'b1, 32'hCAFE_0300);
    issue(SRC_I, 32'h400, 1'b0, 32'h0);
    iq.delete(0);  // presented one cycle later below
    exp_acc(32'h400, 1'b0, 32'h0);
    @(negedge clk);
    chk("lock_c1_addr", 96'(ds_req.addr), 96'(32'h300));
    chk("lock_c1_vld", 96'(ds_req.vld), 96'(1));
    step();
    iq.push_back(mk(32'h400, 1'b0, 32'h0));
    @(negedge clk);
    chk("lock_c2_addr", 96'(ds_req.addr), 96'(32'h300));
    chk("lock_c2_wdata", 96'(ds_req.wdata), 96'(32'hCAFE_0300));
    chk("lock_c2_i_rdy", 96'(i_req.rdy), 96'(0));
    step();
    @(negedge clk);
    chk("lock_c3_addr", 96'(ds_req.addr), 96'(32'h300));
    step();
    ds_req.rdy = 1'b1;
    @(negedge clk);
    chk("lock_c4_addr", 96'(ds_req.addr), 96'(32'h300));
    chk("lock_c4_d_rdy", 96'(d_req.rdy), 96'(1));
    drain("lock");

    // Outstanding limit: 4 accepted, 5th blocked until a slot frees
    rsp_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue(SRC_I, 32'h500 + 32'(4 * k), 1'b0, 32'h0);
      exp_acc(32'h500 + 32'(4 * k), 1'b0, 32'h0);
    end
    repeat (8) step();
    @(negedge clk);
    chk("full_i_vld", 96'(i_req.vld), 96'(1));
    chk("full_i_rdy", 96'(i_req.rdy), 96'(0));
    chk("full_req_vld", 96'(ds_req.vld), 96'(0));
    step();
    rsp_en = 1'b1;
    @(negedge clk);
    chk("full_pop_rsp_rdy", 96'(ds_rsp.rdy), 96'(1));
    chk("full_pop_i_rsp_vld", 96'(i_rsp.vld), 96'(1));
    chk("full_pop_i_rdy", 96'(i_req.rdy), 96'(0));
    step();
    rsp_en = 1'b0;
    @(negedge clk);
    chk("after_pop_i_rdy", 96'(i_req.rdy), 96'(1));
    chk("after_pop_addr", 96'(ds_req.addr), 96'(32'h510));
    step();
    rsp_en = 1'b1;
    drain("full");

    // Response back-pressure: head I stalled, D queued behind it
    rsp_en = 1'b0;
    issue(SRC_I, 32'h600, 1'b0, 32'h0);
    exp_acc(32'h600, 1'b0, 32'h0);
    step();
    issue(SRC_D, 32'h700, 1'b0, 32'h0);
    exp_acc(32'h700, 1'b0, 32'h0);
    repeat (4) step();
    i_rsp.rdy = 1'b0;
    rsp_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_rsp_rdy", 96'(ds_rsp.rdy), 96'(0));
      chk("bp_i_vld", 96'(i_rsp.vld), 96'(1));
      chk("bp_d_vld", 96'(d_rsp.vld), 96'(0));
      step();
    end
    i_rsp.rdy = 1'b1;
    @(negedge clk);
    chk("bp_rel_rsp_rdy", 96'(ds_rsp.rdy), 96'(1));
    chk("bp_rel_d_vld", 96'(d_rsp.vld), 96'(0));
    step();
    @(negedge clk);
    chk("bp_next_d_vld", 96'(d_rsp.vld), 96'(1));
    chk("bp_next_i_vld", 96'(i_rsp.vld), 96'(0));
    drain("bp");

    // Spurious response with nothing outstanding
    chk("pre_spur_proto_err", 96'(proto_err), 96'(0));
    spur = 1'b1;
    @(negedge clk);
    chk("spur_rsp_rdy", 96'(ds_rsp.rdy), 96'(1));
    chk("spur_i_vld", 96'(i_rsp.vld), 96'(0));
    chk("spur_d_vld", 96'(d_rsp.vld), 96'(0));
    step();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_proto_err", 96'(proto_err), 96'(1));
    repeat (3) step();
    @(negedge clk);
    chk("spur_proto_err_held", 96'(proto_err), 96'(1));
    rst_n = 1'b0;
    #1;
    chk("spur_proto_err_rst", 96'(proto_err), 96'(0));
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
